jtag_host_shifter: RTL and testbench

JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

---
 rtl/jtag_host_shifter_if.sv | 30 +++
 rtl/jtag_host_shifter.sv | 147 ++++++++++++++
 tb/tb_jtag_host_shifter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_host_shifter_if.sv
// Request/response bundle between a host and jtag_host_shifter.
// rsp_err exists only when JTAG_HOST_IR_CHECK_EN is defined.
interface jtag_host_shifter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_ir;
  logic [4:0]  req_len;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
`ifdef JTAG_HOST_IR_CHECK_EN
  logic        rsp_err;
`endif

  modport master (
    output req_valid, req_is_ir, req_len, req_data,
    input  req_ready, rsp_valid, rsp_data
`ifdef JTAG_HOST_IR_CHECK_EN
    , input rsp_err
`endif
  );

  modport slave (
    input  req_valid, req_is_ir, req_len, req_data,
    output req_ready, rsp_valid, rsp_data
`ifdef JTAG_HOST_IR_CHECK_EN
    , output rsp_err
`endif
  );
endinterface

// File: rtl/jtag_host_shifter.sv
// JTAG host: issues a TAP reset sequence, then performs IR/DR scans of 1..32 bits.
// Optional IR capture check (rsp_err) enabled by defining JTAG_HOST_IR_CHECK_EN.
module jtag_host_shifter #(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_host_shifter_if.slave bus,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  typedef enum logic [2:0] {
    RESET_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
  } tap_state_t;

  localparam logic [3:0] HALF_MAX = 4'(TCK_HALF - 1);

  tap_state_t  state, state_nxt;
  logic [3:0]  half_cnt;
  logic [2:0]  rcnt;
  logic [4:0]  bit_cnt;
  logic [4:0]  len_m1;
  logic [31:0] data_q;
  logic [31:0] rsp_data_q;
  logic        is_ir_q;
  logic        running;
  logic        scan;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        accept, rise, fall;
  logic        tms_nxt, tdi_nxt;

  assign accept = bus.req_valid && ready_q;
  assign rise   = running && !tck && (half_cnt == HALF_MAX);
  assign fall   = running &&  tck && (half_cnt == HALF_MAX);

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Tracked TAP state follows tms on each rising tck; next tms/tdi derive from the new state.
  always_comb begin
    state_nxt = state;
    tms_nxt   = 1'b0;
    tdi_nxt   = 1'b0;
    if (rise) begin
      case (state)
        RESET_SEQ: state_nxt = (rcnt == 3'd5) ? IDLE : RESET_SEQ;
        IDLE:      state_nxt = tms ? SEL_DR : IDLE;
        SEL_DR:    state_nxt = tms ? SEL_IR : CAPTURE;
        SEL_IR:    state_nxt = CAPTURE;
        CAPTURE:   state_nxt = SHIFT;
        SHIFT:     state_nxt = tms ? EXIT1 : SHIFT;
        EXIT1:     state_nxt = UPDATE;
        UPDATE:    state_nxt = IDLE;
        default:   state_nxt = RESET_SEQ;
      endcase
    end
    case (state)
      RESET_SEQ: tms_nxt = (rcnt < 3'd5);
      SEL_DR:    tms_nxt = is_ir_q;
      SHIFT:     tms_nxt = (bit_cnt == len_m1);
      EXIT1:     tms_nxt = 1'b1;
      default:   tms_nxt = 1'b0;
    endcase
    if (state == SHIFT) tdi_nxt = data_q[bit_cnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_SEQ;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck         <= 1'b0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      half_cnt    <= '0;
      rcnt        <= '0;
      bit_cnt     <= '0;
      len_m1      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      is_ir_q     <= 1'b0;
      running     <= 1'b1;
      scan        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef JTAG_HOST_IR_CHECK_EN
      bus.rsp_err <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        is_ir_q    <= bus.req_is_ir;
        len_m1     <= bus.req_len - 5'd1;
        data_q     <= bus.req_data;
        rsp_data_q <= '0;
        bit_cnt    <= '0;
        half_cnt   <= '0;
        tms        <= 1'b1;
        tdi        <= 1'b0;
        scan       <= 1'b1;
        running    <= 1'b1;
        ready_q    <= 1'b0;
      end else if (rsp_valid_q) begin
        ready_q <= 1'b1;
      end else if (running) begin
        if (half_cnt == HALF_MAX) begin
          half_cnt <= '0;
          tck      <= ~tck;
          if (!tck) begin
            if (state == RESET_SEQ) rcnt <= rcnt + 3'd1;
            if (state == SHIFT) begin
              rsp_data_q[bit_cnt] <= tdo;
              bit_cnt             <= bit_cnt + 5'd1;
            end
          end else if (state == IDLE) begin
            // Back in Run-Test/Idle after the final TCK: stop and report.
            running <= 1'b0;
            scan    <= 1'b0;
            tms     <= 1'b0;
            tdi     <= 1'b0;
            if (scan) begin
              rsp_valid_q <= 1'b1;
`ifdef JTAG_HOST_IR_CHECK_EN
              bus.rsp_err <= is_ir_q && (rsp_data_q[1:0] != 2'b01);
`endif
            end else begin
              ready_q <= 1'b1;
            end
          end else begin
            tms <= tms_nxt;
            tdi <= tdi_nxt;
          end
        end else begin
          half_cnt <= half_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Directed bench for jtag_host_shifter with a behavioural IEEE 1149.1 TAP target
// (5-bit IR, 1-bit BYPASS DR).
module tb_jtag_host_shifter;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tck, tms, tdi;
  logic tdo   = 1'b0;

  jtag_host_shifter_if bus();

  jtag_host_shifter #(.TCK_HALF(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .tdo   (tdo)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int edges = 0, rsp_cnt = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0;
  logic [255:0] tms_log = '0, tdi_log = '0;

  typedef enum {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t       ts = TLR;
  logic [4:0] ir_cap = 5'b00001;
  logic [4:0] ir_sr = '0;
  logic       byp = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.rsp_valid) begin
      rsp_cnt = rsp_cnt + 1;
      rsp_cyc = cyc;
    end
    if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
  end

  always @(posedge tck) begin
    if (edges < 256) begin
      tms_log[edges] = tms;
      tdi_log[edges] = tdi;
    end
    edges = edges + 1;
  end

  always @(posedge tck) begin
    case (ts)
      TLR:  ts <= tms ? TLR  : RTI;
      RTI:  ts <= tms ? SDS  : RTI;
      SDS:  ts <= tms ? SIS  : CDR;
      CDR:  begin byp <= 1'b0; ts <= tms ? E1DR : SHDR; end
      SHDR: begin byp <= tdi;  ts <= tms ? E1DR : SHDR; end
      E1DR: ts <= tms ? UDR  : PDR;
      PDR:  ts <= tms ? E2DR : PDR;
      E2DR: ts <= tms ? UDR  : SHDR;
      UDR:  ts <= tms ? SDS  : RTI;
      SIS:  ts <= tms ? TLR  : CIR;
      CIR:  begin ir_sr <= ir_cap; ts <= tms ? E1IR : SHIR; end
      SHIR: begin ir_sr <= {tdi, ir_sr[4:1]}; ts <= tms ? E1IR : SHIR; end
      E1IR: ts <= tms ? UIR  : PIR;
      PIR:  ts <= tms ? E2IR : PIR;
      E2IR: ts <= tms ? UIR  : SHIR;
      UIR:  ts <= tms ? SDS  : RTI;
      default: ts <= TLR;
    endcase
  end

  always @(negedge tck)
    tdo <= (ts == SHIR) ? ir_sr[0] : (ts == SHDR) ? byp : 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] seg(input logic [255:0] v, input int b, input int n);
    logic [255:0] s;
    s = v >> b;
    return s[63:0] & ((64'd1 << n) - 64'd1);
  endfunction

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!bus.req_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_timeout"}, 64'(bus.rsp_valid), 64'd1);
  endtask

  // Presents one request for a single clk, then scrambles the fields.
  task automatic issue(input logic is_ir, input logic [4:0] len, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_is_ir = is_ir;
    bus.req_len   = len;
    bus.req_data  = data;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_is_ir = ~is_ir;
    bus.req_len   = 5'd3;
    bus.req_data  = 32'hFFFF_FFFF;
    chk("accepted", 64'(bus.req_ready), 64'd0);
  endtask

  int b, r, e1, n;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_is_ir = 1'b0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tck",   64'(tck), 64'd0);
    chk("rst_tms",   64'(tms), 64'd1);
    chk("rst_tdi",   64'(tdi), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rspv",  64'(bus.rsp_valid), 64'd0);
    chk("rst_rspd",  64'(bus.rsp_data), 64'd0);

    b = edges;
    rst_n = 1'b1;
    wait_ready("rstseq", 200);
    chk("rstseq_edges", 64'(edges - b), 64'd6);
    chk("rstseq_tms", seg(tms_log, b, 6), 64'h1F);
    chk("rstseq_tck_low", 64'(tck), 64'd0);
    repeat (10) @(negedge clk);
    chk("idle_edges", 64'(edges - b), 64'd6);
    chk("idle_tck_low", 64'(tck), 64'd0);

    // IR scan, 5 bits, target captures 00001
    ir_cap = 5'b00001;
    b = edges; r = rsp_cnt;
    issue(1'b1, 5'd5, 32'h11);
    wait_rsp("ir5", 300);
    chk("ir5_ready_low", 64'(bus.req_ready), 64'd0);
    chk("ir5_data",  64'(bus.rsp_data), 64'h1);
    chk("ir5_edges", 64'(edges - b), 64'd11);
    chk("ir5_tms", seg(tms_log, b, 11), 64'h303);
    chk("ir5_tdi", seg(tdi_log, b, 11), 64'h110);
    @(negedge clk);
    chk("ir5_ready_after", 64'(bus.req_ready), 64'd1);
    chk("ir5_rspv_pulse", 64'(bus.rsp_valid), 64'd0);
    chk("ir5_one_rsp", 64'(rsp_cnt - r), 64'd1);
    chk("ir5_data_hold", 64'(bus.rsp_data), 64'h1);

    // IR scan, 1 bit
    b = edges;
    issue(1'b1, 5'd1, 32'h0);
    wait_rsp("ir1", 200);
    chk("ir1_data",  64'(bus.rsp_data), 64'h1);
    chk("ir1_edges", 64'(edges - b), 64'd7);
    chk("ir1_tms", seg(tms_log, b, 7), 64'h33);
    chk("ir1_tdi", seg(tdi_log, b, 7), 64'h0);
    @(negedge clk);

    // DR scan, 32 bits through BYPASS
    b = edges;
    issue(1'b0, 5'd0, 32'hDEAD_BEEF);
    wait_rsp("dr32", 400);
    chk("dr32_data",  64'(bus.rsp_data), 64'hBD5B_7DDE);
    chk("dr32_edges", 64'(edges - b), 64'd37);
    chk("dr32_tms", seg(tms_log, b, 37), 64'hC_0000_0001);
    chk("dr32_tdi", seg(tdi_log, b, 37), 64'hDEAD_BEEF << 3);
`ifdef JTAG_HOST_IR_CHECK_EN
    chk("dr32_err", 64'(bus.rsp_err), 64'd0);
`endif
    @(negedge clk);

    // Back-to-back DR scans with req_valid held high
    wait_ready("b2b", 50);
    b = edges;
    bus.req_valid = 1'b1;
    bus.req_is_ir = 1'b0;
    bus.req_len   = 5'd4;
    bus.req_data  = 32'hA;
    @(negedge clk);
    wait_rsp("b2b_first", 200);
    e1 = edges;
    chk("b2b_first_data", 64'(bus.rsp_data), 64'h4);
    chk("b2b_first_edges", 64'(e1 - b), 64'd9);
    chk("b2b_first_tms", seg(tms_log, b, 9), 64'hC1);
    chk("b2b_ready_low_with_rsp", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("b2b_ready_next", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_second_accepted", 64'(bus.req_ready), 64'd0);
    chk("b2b_accept_gap", 64'(acc_cyc - rsp_cyc), 64'd1);
    chk("b2b_no_tck_between", 64'(edges - e1), 64'd0);
    wait_rsp("b2b_second", 200);
    chk("b2b_second_data", 64'(bus.rsp_data), 64'h4);
    chk("b2b_second_edges", 64'(edges - e1), 64'd9);
    @(negedge clk);

    // Reset asserted in the middle of a DR shift
    b = edges; r = rsp_cnt;
    issue(1'b0, 5'd0, 32'h1234_5678);
    n = 0;
    while ((edges - b) < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_shift", 64'((edges - b) >= 10), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tck",   64'(tck), 64'd0);
    chk("abort_tms",   64'(tms), 64'd1);
    chk("abort_tdi",   64'(tdi), 64'd0);
    chk("abort_ready", 64'(bus.req_ready), 64'd0);
    chk("abort_rspv",  64'(bus.rsp_valid), 64'd0);
    chk("abort_rspd",  64'(bus.rsp_data), 64'd0);
    repeat (5) @(negedge clk);
    b = edges;
    rst_n = 1'b1;
    wait_ready("abort_rstseq", 200);
    chk("abort_rstseq_edges", 64'(edges - b), 64'd6);
    chk("abort_rstseq_tms", seg(tms_log, b, 6), 64'h1F);
    chk("abort_no_rsp", 64'(rsp_cnt - r), 64'd0);

    // IR scan against a target capturing 00000, then a short DR scan
    ir_cap = 5'b00000;
    b = edges;
    issue(1'b1, 5'd5, 32'h1F);
    wait_rsp("irbad", 300);
    chk("irbad_data", 64'(bus.rsp_data), 64'h0);
`ifdef JTAG_HOST_IR_CHECK_EN
    chk("irbad_err", 64'(bus.rsp_err), 64'd1);
`endif
    @(negedge clk);
    b = edges;
    issue(1'b0, 5'd3, 32'h5);
    wait_rsp("dr3", 200);
    chk("dr3_data", 64'(bus.rsp_data), 64'h2);
    chk("dr3_tms", seg(tms_log, b, 8), 64'h61);
    chk("dr3_tdi", seg(tdi_log, b, 8), 64'h28);
`ifdef JTAG_HOST_IR_CHECK_EN
    chk("dr3_err", 64'(bus.rsp_err), 64'd0);
`endif
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
